// File: rtl/fifo_sync_pkg.sv
// Shared constants and helpers for the single-clock FWFT FIFO.
package fifo_sync_pkg;

  localparam int FIFO_ADDR_W_DEF = 4;
  localparam int FIFO_DATA_W_DEF = 8;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Producer/consumer handshake bundle; master drives requests, slave is the FIFO.
interface fifo_sync_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);

  logic                  FIFO_WR_ENA;
  logic [DATA_WIDTH-1:0] FIFO_WR_DATA;
  logic                  FIFO_WR_FULL;
  logic                  FIFO_WR_ALM_FULL;
  logic [ADDR_WIDTH-1:0] FIFO_WR_ALM_COUNT;
  logic                  FIFO_RD_ENA;
  logic [DATA_WIDTH-1:0] FIFO_RD_DATA;
  logic                  FIFO_RD_EMPTY;
  logic                  FIFO_RD_ALM_EMPTY;
  logic [ADDR_WIDTH-1:0] FIFO_RD_ALM_COUNT;

  modport master (
    output FIFO_WR_ENA, FIFO_WR_DATA, FIFO_WR_ALM_COUNT,
    output FIFO_RD_ENA, FIFO_RD_ALM_COUNT,
    input  FIFO_WR_FULL, FIFO_WR_ALM_FULL,
    input  FIFO_RD_DATA, FIFO_RD_EMPTY, FIFO_RD_ALM_EMPTY
  );

  modport slave (
    input  FIFO_WR_ENA, FIFO_WR_DATA, FIFO_WR_ALM_COUNT,
    input  FIFO_RD_ENA, FIFO_RD_ALM_COUNT,
    output FIFO_WR_FULL, FIFO_WR_ALM_FULL,
    output FIFO_RD_DATA, FIFO_RD_EMPTY, FIFO_RD_ALM_EMPTY
  );

endinterface

// File: rtl/fifo_sync_ram.sv
// FIFO storage: synchronous write, asynchronous read, no reset on contents.
module fifo_ram
  import fifo_sync_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_W_DEF,
  parameter int DATA_WIDTH = FIFO_DATA_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with full/empty and programmable
// almost-full/almost-empty flags decoded from the registered occupancy count.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_W_DEF,
  parameter int DATA_WIDTH = FIFO_DATA_W_DEF
) (
  input  logic        FIFO_CLK,
  input  logic        RST,
  fifo_sync_if.slave  bus
);

  localparam int              DEPTH   = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH:0]   w_free;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.FIFO_WR_ENA && !w_full;
  assign w_rd_acc = bus.FIFO_RD_ENA && !w_empty;
  assign w_free   = DEPTH_C - r_count;

  always_ff @(posedge FIFO_CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Simultaneous accepted write and read leave the occupancy unchanged.
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (FIFO_CLK),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.FIFO_WR_DATA),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  // Flags depend only on the registered count; thresholds act in the same cycle.
  assign bus.FIFO_WR_FULL      = w_full;
  assign bus.FIFO_RD_EMPTY     = w_empty;
  assign bus.FIFO_WR_ALM_FULL  = (w_free <= {1'b0, bus.FIFO_WR_ALM_COUNT});
  assign bus.FIFO_RD_ALM_EMPTY = (r_count <= {1'b0, bus.FIFO_RD_ALM_COUNT});
  assign bus.FIFO_RD_DATA      = w_empty ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: reset, fill/drain, FWFT latency, streaming with wraps,
// concurrent access at the boundaries, thresholds and asynchronous reset.
module tb_fifo_sync;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  fifo_sync_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  fifo_sync #(4, 8) dut (
    .FIFO_CLK (clk),
    .RST      (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.FIFO_WR_ENA = 1'b0;
    bus.FIFO_RD_ENA = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.FIFO_WR_ENA  = 1'b1;
    bus.FIFO_WR_DATA = d;
    tick();
    bus.FIFO_WR_ENA  = 1'b0;
  endtask

  initial begin
    int wcnt;
    int rcnt;
    logic do_wr;
    logic do_rd;

    rst = 1'b1;
    bus.FIFO_WR_ENA       = 1'b0;
    bus.FIFO_WR_DATA      = 8'h00;
    bus.FIFO_RD_ENA       = 1'b0;
    bus.FIFO_WR_ALM_COUNT = 4'd1;
    bus.FIFO_RD_ALM_COUNT = 4'd0;

    // 1: reset values, during and after release
    repeat (2) tick();
    chk("rst_empty", bus.FIFO_RD_EMPTY, 1);
    chk("rst_alm_empty", bus.FIFO_RD_ALM_EMPTY, 1);
    chk("rst_full", bus.FIFO_WR_FULL, 0);
    chk("rst_alm_full", bus.FIFO_WR_ALM_FULL, 0);
    chk("rst_rd_data", bus.FIFO_RD_DATA, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_empty", bus.FIFO_RD_EMPTY, 1);
    chk("idle_alm_empty", bus.FIFO_RD_ALM_EMPTY, 1);
    chk("idle_full", bus.FIFO_WR_FULL, 0);
    chk("idle_alm_full", bus.FIFO_WR_ALM_FULL, 0);
    chk("idle_rd_data", bus.FIFO_RD_DATA, 0);

    // 2: fill to full with WR_ALM_COUNT=1, overflow write, drain
    for (int i = 0; i < 16; i++) begin
      push(i[7:0]);
      if (i == 13) chk("fill14_alm_full", bus.FIFO_WR_ALM_FULL, 0);
      if (i == 14) begin
        chk("fill15_alm_full", bus.FIFO_WR_ALM_FULL, 1);
        chk("fill15_full", bus.FIFO_WR_FULL, 0);
      end
    end
    chk("fill16_full", bus.FIFO_WR_FULL, 1);
    chk("fill16_head", bus.FIFO_RD_DATA, 8'h00);
    push(8'hAA);
    chk("ovf_full", bus.FIFO_WR_FULL, 1);
    chk("ovf_head", bus.FIFO_RD_DATA, 8'h00);
    bus.FIFO_RD_ENA = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", bus.FIFO_RD_DATA, i);
      tick();
      if (i == 0) chk("drain1_full", bus.FIFO_WR_FULL, 0);
    end
    idle();
    chk("drain_empty", bus.FIFO_RD_EMPTY, 1);
    chk("drain_rd_data", bus.FIFO_RD_DATA, 0);
    tick();
    chk("drain_stays_empty", bus.FIFO_RD_EMPTY, 1);

    // 3: first-word-fall-through latency
    push(8'h5A);
    chk("fwft_empty", bus.FIFO_RD_EMPTY, 0);
    chk("fwft_data", bus.FIFO_RD_DATA, 8'h5A);
    bus.FIFO_RD_ENA = 1'b1;
    tick();
    idle();
    chk("fwft_pop_empty", bus.FIFO_RD_EMPTY, 1);
    chk("fwft_pop_data", bus.FIFO_RD_DATA, 0);

    // 4: stream 256 bytes through with a throttled reader
    wcnt = 0;
    rcnt = 0;
    for (int cyc = 0; cyc < 3000 && rcnt < 256; cyc++) begin
      do_wr = !bus.FIFO_WR_ALM_FULL && (wcnt < 256);
      do_rd = !bus.FIFO_RD_EMPTY && (cyc % 3 != 0);
      bus.FIFO_WR_ENA  = do_wr;
      bus.FIFO_WR_DATA = wcnt[7:0];
      bus.FIFO_RD_ENA  = do_rd;
      if (do_rd) begin
        chk("stream_data", bus.FIFO_RD_DATA, rcnt[7:0]);
        rcnt++;
      end
      if (do_wr && !bus.FIFO_WR_FULL) wcnt++;
      tick();
    end
    idle();
    chk("stream_count", rcnt, 256);
    chk("stream_written", wcnt, 256);
    chk("stream_empty", bus.FIFO_RD_EMPTY, 1);

    // 5: concurrent write+read at full and at empty
    for (int i = 0; i < 16; i++) push(8'h10 + i[7:0]);
    chk("conc_full", bus.FIFO_WR_FULL, 1);
    bus.FIFO_WR_ENA  = 1'b1;
    bus.FIFO_WR_DATA = 8'hEE;
    bus.FIFO_RD_ENA  = 1'b1;
    tick();
    idle();
    chk("conc_full_after", bus.FIFO_WR_FULL, 0);
    bus.FIFO_RD_ENA = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("conc_drain", bus.FIFO_RD_DATA, 8'h10 + i);
      tick();
    end
    idle();
    chk("conc_drained_empty", bus.FIFO_RD_EMPTY, 1);
    bus.FIFO_WR_ENA  = 1'b1;
    bus.FIFO_WR_DATA = 8'h77;
    bus.FIFO_RD_ENA  = 1'b1;
    tick();
    idle();
    chk("conc_empty_wr", bus.FIFO_RD_EMPTY, 0);
    chk("conc_empty_data", bus.FIFO_RD_DATA, 8'h77);
    bus.FIFO_RD_ENA = 1'b1;
    tick();
    idle();
    chk("conc_one_left", bus.FIFO_RD_EMPTY, 1);

    // 6: almost-empty threshold, same-cycle threshold change, async reset
    bus.FIFO_RD_ALM_COUNT = 4'd3;
    #1;
    chk("thr_alm_empty0", bus.FIFO_RD_ALM_EMPTY, 1);
    for (int i = 1; i <= 4; i++) begin
      push(8'h40 + i[7:0]);
      chk("thr_alm_empty", bus.FIFO_RD_ALM_EMPTY, (i <= 3) ? 1 : 0);
    end
    bus.FIFO_RD_ALM_COUNT = 4'd4;
    #1;
    chk("thr_change_ae", bus.FIFO_RD_ALM_EMPTY, 1);
    bus.FIFO_WR_ALM_COUNT = 4'd12;
    #1;
    chk("thr_change_af", bus.FIFO_WR_ALM_FULL, 1);
    bus.FIFO_WR_ALM_COUNT = 4'd11;
    #1;
    chk("thr_change_af_lo", bus.FIFO_WR_ALM_FULL, 0);
    bus.FIFO_WR_ENA  = 1'b1;
    bus.FIFO_WR_DATA = 8'h99;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_empty", bus.FIFO_RD_EMPTY, 1);
    chk("arst_rd_data", bus.FIFO_RD_DATA, 0);
    chk("arst_full", bus.FIFO_WR_FULL, 0);
    chk("arst_alm_full", bus.FIFO_WR_ALM_FULL, 0);
    idle();
    #1;
    rst = 1'b0;
    push(8'h3C);
    chk("post_rst_data", bus.FIFO_RD_DATA, 8'h3C);
    chk("post_rst_ae", bus.FIFO_RD_ALM_EMPTY, 1);
    push(8'h3D);
    bus.FIFO_RD_ENA = 1'b1;
    tick();
    idle();
    chk("post_rst_second", bus.FIFO_RD_DATA, 8'h3D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
